// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage: control/type bit positions,
// the link register number and the writeback FSM state type.
package pipeline_pkg;

    localparam int CTRL_LOADS_BIT    = 8;
    localparam int CTRL_REGWRITE_BIT = 9;

    localparam int ITYPE_BL_BIT  = 2;
    localparam int ITYPE_BLX_BIT = 4;

    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_MEM = 2'd2
    } wb_state_t;

    // True when the instruction type writes the return address to the link register.
    function automatic logic is_link_type(input logic [5:0] itype);
        return itype[ITYPE_BL_BIT] | itype[ITYPE_BLX_BIT];
    endfunction

endpackage

// File: rtl/pipeline_4_writeback_wait_timer.sv
// Saturating stall-cycle counter for loads waiting on memory.
// timeout is asserted during the stalled cycle whose count step reaches LIMIT,
// so the owner can drop the load on that same edge.
module wb_wait_timer #(
    parameter int LIMIT = 15,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step while enabled and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of clr so the owner's completion logic has no combinational loop.
    assign timeout = en && (count_q >= LAST_C);

endmodule

// File: rtl/pipeline_4_writeback.sv
// Writeback stage: captures a retiring instruction and drives the single
// register-file write port. Loads stall the pipeline until mem_ready or a
// bounded timeout (which drops the load and sets the sticky mem_err flag).
// Optional bypass outputs are enabled with the macro WB_FORWARD_EN.
module pipeline_4_writeback
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [21:0] control_in,
    input  logic [2:0]  num_Rd_in,
    input  logic [5:0]  inst_type_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] link_in,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic        stall,
    output logic        w_en,
    output logic [2:0]  w_num,
    output logic [15:0] w_data,
    output logic        mem_err,
    output logic        fwd_valid,
    output logic [2:0]  fwd_num,
    output logic [15:0] fwd_data
);

    wb_state_t   state_q;
    wb_state_t   state_d;

    logic        loads_q;
    logic        regwrite_q;
    logic        link_sel_q;
    logic [2:0]  rd_q;
    logic [15:0] alu_q;
    logic [7:0]  link_q;

    logic        mem_err_q;
    logic        mem_err_d;

    logic        capture;
    logic        complete;
    logic        timed_out;

    // Control and type bits not consumed by this stage.
    logic        unused_bits;
    assign unused_bits = ^{control_in[21:10], control_in[7:0],
                           inst_type_in[5], inst_type_in[3], inst_type_in[1:0],
                           link_in[15:8]};

    // Upstream must hold while a load is still waiting for data.
    assign stall   = (state_q == WAIT_MEM) && !mem_ready;
    assign capture = update && !stall;

    // A non-load retires in its first cycle; a load on data arrival or timeout.
    assign complete = (state_q == EXEC) ||
                      ((state_q == WAIT_MEM) && (mem_ready || timed_out));

    wb_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (capture || complete),
        .en      (stall),
        .timeout (timed_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: completion returns to IDLE unless a new instruction is captured on the same edge.
    always_comb begin
        state_d = state_q;
        if (complete) begin
            state_d = IDLE;
        end
        if (capture) begin
            state_d = control_in[CTRL_LOADS_BIT] ? WAIT_MEM : EXEC;
        end
    end

    // Stage registers: only the fields the write port needs are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q    <= 1'b0;
            regwrite_q <= 1'b0;
            link_sel_q <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            link_q     <= '0;
        end else if (capture) begin
            loads_q    <= control_in[CTRL_LOADS_BIT];
            regwrite_q <= control_in[CTRL_REGWRITE_BIT];
            link_sel_q <= is_link_type(inst_type_in);
            rd_q       <= num_Rd_in;
            alu_q      <= alu_result_in;
            link_q     <= link_in[7:0];
        end
    end

    // Sticky memory error: set when a load is dropped on timeout.
    always_comb begin
        mem_err_d = mem_err_q;
        if ((state_q == WAIT_MEM) && timed_out && !mem_ready) begin
            mem_err_d = 1'b1;
        end
    end

    // Memory error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    // Write port: link writes take priority over the ALU result; loads write memory data.
    always_comb begin
        w_en   = 1'b0;
        w_num  = '0;
        w_data = '0;
        case (state_q)
            EXEC: begin
                if (regwrite_q && !loads_q) begin
                    w_en = 1'b1;
                    if (link_sel_q) begin
                        w_num  = LINK_REG;
                        w_data = {8'h00, link_q};
                    end else begin
                        w_num  = rd_q;
                        w_data = alu_q;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_ready && regwrite_q) begin
                    w_en   = 1'b1;
                    w_num  = rd_q;
                    w_data = mem_data;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef WB_FORWARD_EN
    // Bypass mirrors the write port so the read stage sees the value this cycle.
    assign fwd_valid = w_en;
    assign fwd_num   = w_num;
    assign fwd_data  = w_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_num   = 3'd0;
    assign fwd_data  = 16'd0;
`endif

endmodule
